video_timing_tracker: RTL and testbench

// - Input stage in front of video2ram, in the Dreamcast pixel-clock domain.
// - Turns raw active-low hsync/vsync into the 12-bit counterX/counterY raster

---
 rtl/video_timing_tracker.sv | 150 +++++++++++++++
 tb/tb_video_timing_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_tracker.sv
// Raster tracker: turns active-low hsync/vsync into counterX/counterY, aligns RGB,
// classifies 240p vs 480-line sources and flags hsync loss. TIMING_STATS_EN adds debug length outputs.
module video_timing_tracker #(
  parameter int H_TIMEOUT     = 4096,
  parameter int LD_THRESHOLD  = 300,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync_n,
  input  logic        vsync_n,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [11:0] counterX,
  output logic [11:0] counterY,
  output logic        line_doubler,
  output logic        frame_start,
  output logic        signal_lost
`ifdef TIMING_STATS_EN
  ,
  output logic [11:0] line_length,
  output logic [11:0] frame_lines
`endif
);

  localparam int          TW     = $clog2(H_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(H_TIMEOUT);
  localparam logic [12:0] LD_TH  = 13'(LD_THRESHOLD);
  localparam logic [1:0]  STAB   = 2'(STABLE_FRAMES);
  localparam logic [11:0] CMAX   = 12'hFFF;

  logic          hs1, hs2, vs1, vs2;
  logic          h_edge, v_edge, y_reset;
  logic [23:0]   px1;
  logic          vs_pending;
  logic [12:0]   lines;
  logic          is_240;
  logic          seen_frame, prev_cls;
  logic [1:0]    stab_cnt, stab_next;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs1 <= 1'b0;
      hs2 <= 1'b0;
      vs1 <= 1'b0;
      vs2 <= 1'b0;
    end else begin
      hs1 <= hsync_n;
      hs2 <= hs1;
      vs1 <= vsync_n;
      vs2 <= vs1;
    end
  end

  assign h_edge  = hs2 & ~hs1;
  assign v_edge  = vs2 & ~vs1;
  assign y_reset = h_edge & (vs_pending | v_edge);

  // Two-deep pixel pipe matches the two-stage sync path feeding the counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px1       <= '0;
      {R, G, B} <= '0;
    end else begin
      px1       <= {R_in, G_in, B_in};
      {R, G, B} <= px1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counterX    <= '0;
      counterY    <= '0;
      vs_pending  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (h_edge)               counterX <= '0;
      else if (counterX != CMAX) counterX <= counterX + 12'd1;

      if (h_edge)      vs_pending <= 1'b0;
      else if (v_edge) vs_pending <= 1'b1;

      if (y_reset) begin
        counterY    <= '0;
        frame_start <= 1'b1;
      end else if (h_edge && counterY != CMAX) begin
        counterY <= counterY + 12'd1;
      end
    end
  end

  assign lines  = {1'b0, counterY} + 13'd1;
  assign is_240 = lines < LD_TH;

  always_comb begin
    stab_next = 2'd1;
    if (stab_cnt != 2'd0 && is_240 == prev_cls)
      stab_next = (stab_cnt == 2'd3) ? 2'd3 : stab_cnt + 2'd1;
  end

  // The first counterY reset after reset closes a partial frame, so it only arms detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_frame   <= 1'b0;
      prev_cls     <= 1'b0;
      stab_cnt     <= '0;
      line_doubler <= 1'b0;
    end else if (y_reset) begin
      if (!seen_frame) begin
        seen_frame <= 1'b1;
      end else begin
        stab_cnt <= stab_next;
        prev_cls <= is_240;
        if (stab_next >= STAB) line_doubler <= is_240;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      signal_lost <= 1'b0;
    end else if (h_edge) begin
      to_cnt      <= '0;
      signal_lost <= 1'b0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt + 1'b1 == TO_MAX) signal_lost <= 1'b1;
    end
  end

`ifdef TIMING_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_length <= '0;
      frame_lines <= '0;
    end else begin
      if (h_edge)  line_length <= (counterX == CMAX) ? CMAX : counterX + 12'd1;
      if (y_reset) frame_lines <= lines[12] ? CMAX : lines[11:0];
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_tracker.sv
// Scoreboard bench: the raster driver queues expected outputs two cycles ahead, a negedge monitor checks them.
module tb_video_timing_tracker;
  localparam int HSW = 8;
  localparam int LEN = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        hsync_n, vsync_n;
  logic [7:0]  R_in, G_in, B_in, R, G, B;
  logic [11:0] counterX, counterY;
  logic        line_doubler, frame_start, signal_lost;
`ifdef TIMING_STATS_EN
  logic [11:0] line_length, frame_lines;
`endif

  always #5 clock = ~clock;

  video_timing_tracker #(.H_TIMEOUT(4096), .LD_THRESHOLD(20), .STABLE_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .R_in(R_in), .G_in(G_in), .B_in(B_in), .R(R), .G(G), .B(B),
    .counterX(counterX), .counterY(counterY), .line_doubler(line_doubler),
    .frame_start(frame_start), .signal_lost(signal_lost)
`ifdef TIMING_STATS_EN
    , .line_length(line_length), .frame_lines(frame_lines)
`endif
  );

  typedef struct {
    int          cyc;
    bit          cx, cy, cll, cfl;
    logic [11:0] x, y, ll, fl;
    bit          fs, ld, sl;
    logic [7:0]  r, g, b;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         known_x, known_y, eld, len_valid, lines_valid;
  int         prev_len, prev_lines;
  logic [7:0] ramp;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) chk("missed_slot", e.cyc, cyc);
      if (e.cx) chk("counterX", int'(counterX), int'(e.x));
      if (e.cy) chk("counterY", int'(counterY), int'(e.y));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("line_doubler", int'(line_doubler), int'(e.ld));
      chk("signal_lost", int'(signal_lost), int'(e.sl));
      chk("R", int'(R), int'(e.r));
      chk("G", int'(G), int'(e.g));
      chk("B", int'(B), int'(e.b));
`ifdef TIMING_STATS_EN
      if (e.cll) chk("line_length", int'(line_length), int'(e.ll));
      if (e.cfl) chk("frame_lines", int'(frame_lines), int'(e.fl));
`endif
    end
  end

  task automatic tick(input bit h, input bit v, input int xin, input int y,
                      input bit fst, input bit cll, input bit cfl);
    exp_t e;
    hsync_n = h;
    vsync_n = v;
    R_in    = known_x ? xin[7:0] : 8'd0;
    G_in    = ramp;
    B_in    = ~ramp;
    e.cyc = cyc + 2;
    e.cx  = known_x;
    e.x   = (xin > 4095) ? 12'hFFF : xin[11:0];
    e.cy  = known_y;
    e.y   = y[11:0];
    e.fs  = fst;
    e.ld  = eld;
    e.sl  = known_x && (xin >= 4096);
    e.r   = R_in;
    e.g   = ramp;
    e.b   = ~ramp;
    e.cll = cll;
    e.ll  = prev_len[11:0];
    e.cfl = cfl;
    e.fl  = prev_lines[11:0];
    q.push_back(e);
    ramp++;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_line(input int y, input int len, input bit fst,
                            input bit vs_start, input bit vs_mid);
    bit cll, cfl, v;
    cll = len_valid;
    cfl = fst && lines_valid;
    for (int x = 0; x < len; x++) begin
      v = !((vs_start && x < HSW) || (vs_mid && x >= len / 2 && x < len / 2 + HSW));
      if (x == 0) begin
        known_x = 1'b1;
        if (fst) known_y = 1'b1;
      end
      tick(x >= HSW, v, x, y, fst && x == 0, cll && x == 0, cfl && x == 0);
    end
    prev_len  = len;
    len_valid = (len <= 4095);
  endtask

  task automatic drive_frame(input int lines, input bit ld, input bit vs_start, input bit vs_last);
    eld = ld;
    for (int l = 0; l < lines; l++)
      drive_line(l, LEN, l == 0, vs_start && l == 0, vs_last && l == lines - 1);
    prev_lines  = lines;
    lines_valid = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_X"}, int'(counterX), 0);
    chk({tag, "_Y"}, int'(counterY), 0);
    chk({tag, "_RGB"}, int'({R, G, B}), 0);
    chk({tag, "_ld"}, int'(line_doubler), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_sl"}, int'(signal_lost), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1;
    R_in = '0; G_in = '0; B_in = '0; ramp = '0;
    known_x = 0; known_y = 0; eld = 0; len_valid = 0; lines_valid = 0;
    prev_len = 0; prev_lines = 0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) tick(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    // 26-line frames classify as 480, 13-line frames as 240p (threshold 20)
    drive_frame(26, 1'b0, 1'b1, 1'b0);
    drive_frame(26, 1'b0, 1'b1, 1'b0);
    drive_frame(26, 1'b0, 1'b1, 1'b0);
    drive_frame(13, 1'b0, 1'b1, 1'b0);
    drive_frame(13, 1'b0, 1'b1, 1'b0);
    drive_frame(13, 1'b1, 1'b1, 1'b0);
    drive_frame(26, 1'b1, 1'b1, 1'b0);
    drive_frame(26, 1'b1, 1'b1, 1'b0);
    drive_frame(26, 1'b0, 1'b1, 1'b1);

    // Frame opened by a vsync left pending mid-line, full-width lines, then hsync loss
    eld = 1'b0;
    drive_line(0, 858, 1'b1, 1'b0, 1'b0);
    drive_line(1, 858, 1'b0, 1'b0, 1'b0);
    drive_line(2, 4200, 1'b0, 1'b0, 1'b0);
    drive_line(3, LEN, 1'b0, 1'b0, 1'b0);

    // Reset mid-line once counterX shows 400
    for (int x = 0; x < 402; x++) tick(x >= HSW, 1'b1, x, 4, 1'b0, 1'b0, 1'b0);
    chk("x_before_reset", int'(counterX), 400);
    reset = 1'b1;
    #1;
    check_all_zero("midline_reset");
    q.delete();
    known_x = 0; known_y = 0; eld = 0; len_valid = 0; lines_valid = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) tick(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    drive_frame(13, 1'b0, 1'b1, 1'b0);
    drive_frame(13, 1'b0, 1'b1, 1'b0);
    drive_frame(1, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
